sequenciador_multiciclo: RTL and testbench

SEQUENCIADOR_MULTICICLO -- requirements
Module: sequenciador_multiciclo

---
 rtl/sequenciador_multiciclo.sv | 193 +++++++++++++++++++
 tb/tb_sequenciador_multiciclo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_multiciclo.sv
// Multi-cycle instruction sequencer: walks each opcode through fetch/decode/execute/memory/writeback
// and drives the datapath strobes, with a memory-wait watchdog that latches a sticky bus error.
module sequenciador_multiciclo #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [5:0]  op_code,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        alu_op,
    output logic        mem_to_reg,
    output logic [5:0]  sinal_da_conta,
    output logic        busy,
    output logic        bus_error,
    output logic [3:0]  state,
    output logic [15:0] instret
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        EXEC_I = 4'd4,
        ADDR   = 4'd5,
        MEM_RD = 4'd6,
        MEM_WR = 4'd7,
        WB_R   = 4'd8,
        WB_I   = 4'd9,
        WB_MEM = 4'd10,
        BRANCH = 4'd11,
        JUMP   = 4'd12,
        ERROR  = 4'd15
    } stateT;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [5:0] ALU_ADD     = 6'b000000;
    localparam logic [5:0] ALU_SUB     = 6'b000100;

    stateT       curState;
    stateT       nextState;
    logic [7:0]  waitCnt;
    logic [15:0] instretCnt;
    logic        retire;
    logic        waitState;
    logic        timedOut;
    logic        branchTaken;

    assign waitState = (curState == FETCH) || (curState == MEM_RD) || (curState == MEM_WR);
    // A completing transfer always wins over the watchdog on the same cycle.
    assign timedOut  = (waitCnt == TIMEOUT_CNT) && !mem_ready;

    // NOTE: every register updates with <= so all flops sample the same pre-edge values;
    // the async reset branch clears the whole machine, including the counters, mid-wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState   <= IDLE;
            waitCnt    <= '0;
            instretCnt <= '0;
        end else begin
            curState <= nextState;
            if (nextState != curState)
                waitCnt <= '0;
            else if (waitState && !mem_ready)
                waitCnt <= waitCnt + 8'd1;
            if (retire)
                instretCnt <= instretCnt + 16'd1;
        end
    end

    // NOTE: defaults at the top of each combinational block keep every path assigned, so no latches.
    always_comb begin
        nextState = curState;
        retire    = 1'b0;
        unique case (curState)
            IDLE:   if (run) nextState = FETCH;
            FETCH: begin
                if (mem_ready)     nextState = DECODE;
                else if (timedOut) nextState = ERROR;
            end
            DECODE: begin
                case (op_code)
                    6'd0:                   nextState = EXEC_R;
                    6'd1:                   nextState = EXEC_I;
                    6'd2, 6'd3, 6'd4, 6'd5: nextState = BRANCH;
                    6'd6, 6'd7:             nextState = ADDR;
                    6'd8:                   nextState = JUMP;
                    default:                retire    = 1'b1;
                endcase
            end
            EXEC_R: nextState = WB_R;
            EXEC_I: nextState = WB_I;
            ADDR:   nextState = (op_code == 6'd7) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (mem_ready)     nextState = WB_MEM;
                else if (timedOut) nextState = ERROR;
            end
            MEM_WR: begin
                if (mem_ready)     retire    = 1'b1;
                else if (timedOut) nextState = ERROR;
            end
            WB_R, WB_I, WB_MEM, BRANCH, JUMP: retire = 1'b1;
            ERROR:   nextState = ERROR;
            default: nextState = IDLE;
        endcase
        if (retire)
            nextState = run ? FETCH : IDLE;
    end

    always_comb begin
        case (op_code)
            6'd2:    branchTaken = alu_zero;
            6'd3:    branchTaken = !alu_zero;
            6'd4:    branchTaken = alu_zero || alu_neg;
            6'd5:    branchTaken = !alu_zero && !alu_neg;
            default: branchTaken = 1'b0;
        endcase
    end

    always_comb begin
        pc_write       = 1'b0;
        pc_src         = 1'b0;
        ir_write       = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        reg_dst        = 1'b0;
        alu_src        = 1'b0;
        alu_op         = 1'b0;
        mem_to_reg     = 1'b0;
        sinal_da_conta = ALU_ADD;
        case (curState)
            FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            EXEC_R: begin
                alu_op  = 1'b1;
                reg_dst = 1'b1;
            end
            WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_op    = 1'b1;
            end
            EXEC_I, ADDR: alu_src = 1'b1;
            WB_I: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            BRANCH: begin
                sinal_da_conta = ALU_SUB;
                pc_src         = 1'b1;
                pc_write       = branchTaken;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (curState != IDLE) && (curState != ERROR);
    assign bus_error = (curState == ERROR);
    assign state     = curState;
    assign instret   = instretCnt;

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Directed bench for sequenciador_multiciclo (TIMEOUT=4): walks every instruction class,
// wait/timeout boundaries, instret wrap and asynchronous reset, with hand-computed expectations.
module tb_sequenciador_multiciclo;

    localparam logic [9:0] S_NONE = 10'b0000000000; // {pw,ps,irw,mr,mw,rw,rd,as,ao,mtr}
    localparam logic [9:0] S_FW   = 10'b0001000000;
    localparam logic [9:0] S_FR   = 10'b1011000000;
    localparam logic [9:0] S_XR   = 10'b0000001010;
    localparam logic [9:0] S_WR   = 10'b0000011010;
    localparam logic [9:0] S_XI   = 10'b0000000100;
    localparam logic [9:0] S_WI   = 10'b0000010100;
    localparam logic [9:0] S_AD   = 10'b0000000100;
    localparam logic [9:0] S_MR   = 10'b0001000100;
    localparam logic [9:0] S_WM   = 10'b0000010001;
    localparam logic [9:0] S_MW   = 10'b0000100100;
    localparam logic [9:0] S_BT   = 10'b1100000000;
    localparam logic [9:0] S_BN   = 10'b0100000000;
    localparam logic [9:0] S_JP   = 10'b1100000000;
    localparam logic [5:0] ADD    = 6'b000000;
    localparam logic [5:0] SUB    = 6'b000100;

    logic        clk = 1'b0;
    logic        rst_n, run, mem_ready, alu_zero, alu_neg;
    logic [5:0]  op_code;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
    logic        reg_dst, alu_src, alu_op, mem_to_reg, busy, bus_error;
    logic [5:0]  sinal_da_conta;
    logic [3:0]  state;
    logic [15:0] instret;

    int nCmp = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    sequenciador_multiciclo #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .op_code(op_code), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .sinal_da_conta(sinal_da_conta), .busy(busy),
        .bus_error(bus_error), .state(state), .instret(instret)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkState(input string tag, input logic [3:0] st,
                              input logic [9:0] sb, input logic [5:0] sdc);
        check({tag, ".state"}, {12'd0, state}, {12'd0, st});
        check({tag, ".ctl"}, {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write,
                              reg_dst, alu_src, alu_op, mem_to_reg, sinal_da_conta}, {sb, sdc});
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; op_code = 6'd0; mem_ready = 1'b0;
        alu_zero = 1'b0; alu_neg = 1'b0;
        #2;
        checkState("reset", 4'd0, S_NONE, ADD);
        check("reset.busy", {15'd0, busy}, 16'd0);
        check("reset.buserr", {15'd0, bus_error}, 16'd0);
        check("reset.instret", instret, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); run = 1'b1; op_code = 6'd0; mem_ready = 1'b1; #1;
        checkState("r.idle", 4'd0, S_NONE, ADD);

        // R-type: 1,2,3,8,1
        @(negedge clk); #1; checkState("r.fetch", 4'd1, S_FR, ADD);
        check("r.busy", {15'd0, busy}, 16'd1);
        @(negedge clk); #1; checkState("r.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("r.exec", 4'd3, S_XR, ADD);
        @(negedge clk); #1; checkState("r.wb", 4'd8, S_WR, ADD);
        check("r.instret0", instret, 16'd0);
        // addi
        @(negedge clk); op_code = 6'd1; #1; checkState("i.fetch", 4'd1, S_FR, ADD);
        check("r.instret1", instret, 16'd1);
        @(negedge clk); #1; checkState("i.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("i.exec", 4'd4, S_XI, ADD);
        @(negedge clk); #1; checkState("i.wb", 4'd9, S_WI, ADD);
        // lw with 3 wait cycles in MEM_RD
        @(negedge clk); op_code = 6'd6; #1; checkState("lw.fetch", 4'd1, S_FR, ADD);
        check("i.instret", instret, 16'd2);
        @(negedge clk); #1; checkState("lw.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); mem_ready = 1'b0; #1; checkState("lw.addr", 4'd5, S_AD, ADD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1; checkState("lw.memrd.wait", 4'd6, S_MR, ADD);
        end
        @(negedge clk); mem_ready = 1'b1; #1; checkState("lw.memrd.rdy", 4'd6, S_MR, ADD);
        @(negedge clk); #1; checkState("lw.wbmem", 4'd10, S_WM, ADD);
        // sw
        @(negedge clk); op_code = 6'd7; #1; checkState("sw.fetch", 4'd1, S_FR, ADD);
        check("lw.instret", instret, 16'd3);
        @(negedge clk); #1; checkState("sw.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("sw.addr", 4'd5, S_AD, ADD);
        @(negedge clk); #1; checkState("sw.memwr", 4'd7, S_MW, ADD);
        // beq taken, bne not taken (alu_zero=1)
        @(negedge clk); op_code = 6'd2; alu_zero = 1'b1; #1;
        checkState("beq.fetch", 4'd1, S_FR, ADD);
        check("sw.instret", instret, 16'd4);
        @(negedge clk); #1; checkState("beq.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("beq.taken", 4'd11, S_BT, SUB);
        @(negedge clk); op_code = 6'd3; #1; checkState("bne.fetch", 4'd1, S_FR, ADD);
        @(negedge clk); #1; checkState("bne.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("bne.nottaken", 4'd11, S_BN, SUB);
        // blez
        @(negedge clk); op_code = 6'd4; alu_zero = 1'b0; alu_neg = 1'b1; #1;
        checkState("blez.fetch", 4'd1, S_FR, ADD);
        check("bne.instret", instret, 16'd6);
        @(negedge clk); #1; checkState("blez.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("blez.neg", 4'd11, S_BT, SUB);
        alu_neg = 1'b0; #1; checkState("blez.pos", 4'd11, S_BN, SUB);
        // bgtz
        @(negedge clk); op_code = 6'd5; #1; checkState("bgtz.fetch", 4'd1, S_FR, ADD);
        @(negedge clk); #1; checkState("bgtz.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("bgtz.pos", 4'd11, S_BT, SUB);
        alu_neg = 1'b1; #1; checkState("bgtz.neg", 4'd11, S_BN, SUB);
        alu_neg = 1'b0; alu_zero = 1'b1; #1; checkState("bgtz.zero", 4'd11, S_BN, SUB);
        alu_zero = 1'b0;
        // jump
        @(negedge clk); op_code = 6'd8; #1; checkState("j.fetch", 4'd1, S_FR, ADD);
        check("bgtz.instret", instret, 16'd8);
        @(negedge clk); #1; checkState("j.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("j.jump", 4'd12, S_JP, ADD);
        // illegal opcode twice, second one ends in IDLE
        @(negedge clk); op_code = 6'b111111; #1; checkState("ill.fetch", 4'd1, S_FR, ADD);
        check("j.instret", instret, 16'd9);
        @(negedge clk); #1; checkState("ill.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); run = 1'b0; #1; checkState("ill2.fetch", 4'd1, S_FR, ADD);
        check("ill.instret", instret, 16'd10);
        @(negedge clk); #1; checkState("ill2.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("ill2.idle", 4'd0, S_NONE, ADD);
        check("ill2.busy", {15'd0, busy}, 16'd0);
        check("ill2.instret", instret, 16'd11);

        // ready arrives on the 5th FETCH cycle exactly at the timeout boundary
        @(negedge clk); run = 1'b1; mem_ready = 1'b0; op_code = 6'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1; checkState("to.fetch.wait", 4'd1, S_FW, ADD);
        end
        @(negedge clk); mem_ready = 1'b1; #1; checkState("to.fetch.rdy", 4'd1, S_FR, ADD);
        @(negedge clk); run = 1'b0; #1; checkState("to.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("to.exec", 4'd3, S_XR, ADD);
        @(negedge clk); #1; checkState("to.wb", 4'd8, S_WR, ADD);
        @(negedge clk); #1; checkState("to.idle", 4'd0, S_NONE, ADD);
        check("to.instret", instret, 16'd12);
        check("to.buserr", {15'd0, bus_error}, 16'd0);

        // instret wrap 0xFFFF -> 0x0000 on one retire
        force dut.instretCnt = 16'hFFFF; #1;
        release dut.instretCnt; #1;
        check("wrap.preload", instret, 16'hFFFF);
        run = 1'b1; op_code = 6'b111111; mem_ready = 1'b1;
        @(negedge clk); run = 1'b0; #1; checkState("wrap.fetch", 4'd1, S_FR, ADD);
        @(negedge clk); #1; checkState("wrap.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); #1; checkState("wrap.idle", 4'd0, S_NONE, ADD);
        check("wrap.instret", instret, 16'h0000);

        // async reset mid MEM_WR wait with instret=0xFFFF
        force dut.instretCnt = 16'hFFFF; #1;
        release dut.instretCnt; #1;
        run = 1'b1; op_code = 6'd7;
        @(negedge clk); #1; checkState("rst.fetch", 4'd1, S_FR, ADD);
        check("rst.preload", instret, 16'hFFFF);
        @(negedge clk); #1; checkState("rst.decode", 4'd2, S_NONE, ADD);
        @(negedge clk); mem_ready = 1'b0; #1; checkState("rst.addr", 4'd5, S_AD, ADD);
        @(negedge clk); #1; checkState("rst.memwr", 4'd7, S_MW, ADD);
        #2; rst_n = 1'b0; #1;
        checkState("rst.async", 4'd0, S_NONE, ADD);
        check("rst.busy", {15'd0, busy}, 16'd0);
        check("rst.instret", instret, 16'h0000);
        check("rst.buserr", {15'd0, bus_error}, 16'd0);

        // timeout: 5 FETCH cycles without ready -> ERROR, sticky until reset
        @(negedge clk); rst_n = 1'b1; run = 1'b1; op_code = 6'd0; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1; checkState("err.fetch.wait", 4'd1, S_FW, ADD);
        end
        @(negedge clk); #1; checkState("err.state", 4'd15, S_NONE, ADD);
        check("err.buserr", {15'd0, bus_error}, 16'd1);
        check("err.busy", {15'd0, busy}, 16'd0);
        @(negedge clk); mem_ready = 1'b1; #1; checkState("err.sticky", 4'd15, S_NONE, ADD);
        check("err.sticky.buserr", {15'd0, bus_error}, 16'd1);
        rst_n = 1'b0; #1;
        check("err.reset.buserr", {15'd0, bus_error}, 16'd0);
        check("err.reset.state", {12'd0, state}, 16'd0);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
